// File: rtl/eth_rx_cmd_packer.sv
// Ethernet RX header filter and byte-to-word packer.
// Parses the 14-byte MAC header, keeps frames addressed to LOCAL_MAC (or
// broadcast) with an optional EtherType match, and packs the payload
// big-endian into 32-bit AXI-Stream words for the command decoder.
module eth_rx_cmd_packer #(
  parameter logic [47:0] LOCAL_MAC    = 48'h5a0102030405,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter bit          CHECK_ETYPE  = 1'b0,
  parameter logic [15:0] ETYPE        = 16'h88b5
) (
  input  logic        gtx_clk_bufg,
  input  logic        gtx_resetn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned HCNT_W    = 4;
  localparam int unsigned MAC_BYTES = 6;
  localparam logic [HCNT_W-1:0] ETYPE_HI_IDX = HCNT_W'(12);
  localparam logic [HCNT_W-1:0] HDR_LAST_IDX = HCNT_W'(13);

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t              state;
  logic [HCNT_W-1:0]   hdr_cnt;
  logic [1:0]          byte_idx;
  logic [WORD_W-1:0]   pack;
  logic                ucast_ok;
  logic                bcast_ok;
  logic [BYTE_W-1:0]   etype_hi;

  logic                s_fire;
  logic [BYTE_W-1:0]   mac_byte_c;
  logic [WORD_W-1:0]   word_c;
  logic                dest_ok_c;
  logic                etype_ok_c;

  // Input is stalled only while a full output word waits on downstream.
  assign s_axis_tready = gtx_resetn &
                         ((state != PAYLOAD) | ~m_axis_tvalid | m_axis_tready);
  assign s_fire        = s_axis_tvalid & s_axis_tready;

  // Expected destination byte for the current header position (wire order, MSB first).
  always_comb begin
    mac_byte_c = '0;
    case (hdr_cnt)
      HCNT_W'(0): mac_byte_c = LOCAL_MAC[47:40];
      HCNT_W'(1): mac_byte_c = LOCAL_MAC[39:32];
      HCNT_W'(2): mac_byte_c = LOCAL_MAC[31:24];
      HCNT_W'(3): mac_byte_c = LOCAL_MAC[23:16];
      HCNT_W'(4): mac_byte_c = LOCAL_MAC[15:8];
      HCNT_W'(5): mac_byte_c = LOCAL_MAC[7:0];
      default:    mac_byte_c = '0;
    endcase
  end

  // Merge the incoming byte into its lane; lanes below it are still zero in pack.
  always_comb begin
    word_c = pack;
    case (byte_idx)
      2'd0:    word_c[31:24] = s_axis_tdata;
      2'd1:    word_c[23:16] = s_axis_tdata;
      2'd2:    word_c[15:8]  = s_axis_tdata;
      default: word_c[7:0]   = s_axis_tdata;
    endcase
  end

  assign dest_ok_c  = ucast_ok | (ACCEPT_BCAST & bcast_ok);
  assign etype_ok_c = ~CHECK_ETYPE | ({etype_hi, s_axis_tdata} == ETYPE);

  // Frame FSM, header compare, packing, output register and counters.
  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
    if (!gtx_resetn) begin
      state          <= HDR;
      hdr_cnt        <= '0;
      byte_idx       <= '0;
      pack           <= '0;
      ucast_ok       <= 1'b1;
      bcast_ok       <= 1'b1;
      etype_hi       <= '0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tuser   <= 1'b0;
      frames_ok      <= '0;
      frames_dropped <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        HDR: begin
          if (s_fire) begin
            if (hdr_cnt < HCNT_W'(MAC_BYTES)) begin
              ucast_ok <= ucast_ok & (s_axis_tdata == mac_byte_c);
              bcast_ok <= bcast_ok & (s_axis_tdata == 8'hff);
            end
            if (hdr_cnt == ETYPE_HI_IDX) begin
              etype_hi <= s_axis_tdata;
            end
            if (s_axis_tlast) begin
              // Runt: frame ended inside the header.
              frames_dropped <= frames_dropped + CNT_W'(1);
              hdr_cnt        <= '0;
              ucast_ok       <= 1'b1;
              bcast_ok       <= 1'b1;
            end else if (hdr_cnt == HDR_LAST_IDX) begin
              hdr_cnt  <= '0;
              ucast_ok <= 1'b1;
              bcast_ok <= 1'b1;
              if (dest_ok_c && etype_ok_c) begin
                state    <= PAYLOAD;
                byte_idx <= '0;
                pack     <= '0;
              end else begin
                state <= DROP;
              end
            end else begin
              hdr_cnt <= hdr_cnt + HCNT_W'(1);
            end
          end
        end

        PAYLOAD: begin
          if (s_fire) begin
            if ((byte_idx == 2'd3) || s_axis_tlast) begin
              m_axis_tdata  <= word_c;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= s_axis_tlast;
              m_axis_tuser  <= s_axis_tlast & s_axis_tuser;
              pack          <= '0;
              byte_idx      <= '0;
              if (s_axis_tlast) begin
                frames_ok <= frames_ok + CNT_W'(1);
                state     <= HDR;
              end
            end else begin
              pack     <= word_c;
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        DROP: begin
          if (s_fire && s_axis_tlast) begin
            frames_dropped <= frames_dropped + CNT_W'(1);
            state          <= HDR;
          end
        end

        default: state <= HDR;
      endcase
    end
  end

endmodule
